// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder with carry-in, split into STAGES
// registered carry-chain segments of CHUNK = WIDTH/STAGES bits each.
// Sits on a valid/ready stream; a single global stall freezes all stages.
//
// Optional feature macro: PIPE_ADDER_OVF_EN adds the registered signed
// overflow output ovf.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (combinational)
//   a, b       WIDTH-bit operands
//   cin        carry-in to bit 0
//   out_valid  result beat valid (registered)
//   out_ready  consumer accepts the result this cycle
//   sum        a + b + cin modulo 2^WIDTH (registered)
//   cout       carry out of bit WIDTH-1 (registered)
//   ovf        signed overflow (registered, PIPE_ADDER_OVF_EN only)
module pipe_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES_SAFE = (STAGES < 1) ? 1 : STAGES;
    localparam int unsigned CHUNK       = WIDTH / STAGES_SAFE;

    // Reject configurations that cannot be split into equal chunks.
    if ((STAGES < 1) || ((WIDTH % STAGES_SAFE) != 0)) begin : g_param_check
        $error("pipe_adder: WIDTH must be a nonzero multiple of STAGES");
    end

    // Global stall: every stage advances together or holds together.
    logic adv;
    assign in_ready = !out_valid || out_ready;
    assign adv      = in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // REM: operand bits still unresolved on entry; DONE: sum bits resolved on exit.
        localparam int unsigned REM  = WIDTH - k * CHUNK;
        localparam int unsigned DONE = (k + 1) * CHUNK;

        logic [REM-1:0]  a_in;
        logic [REM-1:0]  b_in;
        logic            c_in;
        logic            vld_d;
        logic [DONE-1:0] sum_d;
        logic [CHUNK:0]  add;

        logic            vld_q;
        logic            c_q;
        logic [DONE-1:0] sum_q;

        // Stage inputs: ports for the first stage, previous stage registers otherwise.
        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b;
            assign c_in  = cin;
            assign vld_d = in_valid;
            assign sum_d = add[CHUNK-1:0];
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign vld_d = g_stage[k-1].vld_q;
            assign sum_d = {add[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        // Lowest unresolved chunk plus incoming carry.
        assign add = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                   + (CHUNK+1)'(c_in);

        // Valid, carry and resolved sum bits for this stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vld_d;
                c_q   <= add[CHUNK];
                sum_q <= sum_d;
            end
        end

        // Upper operand bits still to be added by later stages.
        if (k < STAGES - 1) begin : g_fwd
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[REM-1:CHUNK];
                    b_q <= b_in[REM-1:CHUNK];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        // Last stage sees the operand sign bits and the final sum sign bit.
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (a_in[REM-1] == b_in[REM-1])
                          && (add[CHUNK-1] != a_in[REM-1]);
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the team's single-bit combinational full adder.
- Adds two WIDTH-bit operands plus a carry-in across STAGES registered carry-chain segments.
- Each stage resolves one CHUNK = WIDTH/STAGES slice and passes its carry to the next stage.
- Sits between a valid/ready producer and consumer in the datapath, with full backpressure.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); nominal latency in cycles.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with PIPE_ADDER_OVF_EN.

Behaviour:
- Reset:
  - Asserting rst clears every stage valid bit, data register and carry register immediately, without waiting for clk.
  - While reset is held: out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 once rst deasserts.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, combinational; this is a global stall, with no bubble collapsing.
- Stall: when in_ready=0, every stage register holds its value. sum, cout, out_valid and ovf are stable until the output transfer completes.
- Advance: when in_ready=1, every stage shifts forward by one.
  - Stage 0 loads the accepted beat, or valid=0 if no input transfer occurred.
- Stage k (0..STAGES-1):
  - Computes chunk k, bits [k*CHUNK +: CHUNK], as a_chunk + b_chunk + carry_in.
  - carry_in is cin for k=0, otherwise the registered carry from stage k-1.
  - Registers the chunk sum, the chunk carry-out, the already-resolved lower sum bits and the still-unprocessed upper operand bits.
- Latency:
  - A beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1; that is, STAGES register stages with the output taken from the last stage.
  - Throughput is one beat per cycle when out_ready stays high.
- Outputs are driven only from registers; no combinational path from a, b or cin to sum or cout.
- Arithmetic: unsigned modulo 2^WIDTH. cout=1 exactly when a+b+cin >= 2^WIDTH. Both all-ones operands with cin=1 give sum=all-ones, cout=1.
- Bubbles: stages holding valid=0 still shift; their data content is don't-care, but out_valid must be 0 for them.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle are both honoured.
  - in_valid while rst=1 is ignored.
- Reset mid-operation: all in-flight beats are discarded. No partial result is ever presented after rst deasserts.
- Elaboration-time error if WIDTH % STAGES != 0 or STAGES < 1.

Optional Feature:
- Macro PIPE_ADDER_OVF_EN.
- When defined:
  - Port ovf exists and is registered alongside sum.
  - ovf = (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), evaluated per beat.
  - ovf is carried through the pipeline with its beat, holds under stall, and resets to 0.
- When undefined: the ovf port and its registers are absent. All other behaviour is identical.

Test Plan:
- Reset check: rst pulsed between clock edges with beats in flight -> out_valid drops to 0 immediately; sum=0, cout=0; no stale beat emerges after rst is released.
- Streaming, WIDTH=16, STAGES=4, out_ready=1: beats (0x0000,0x0000,0), (0x00FF,0x0001,0), (0xFFFF,0x0001,0), (0xFFFF,0xFFFF,1) on consecutive cycles -> results 0x0000/0, 0x0100/0, 0x0000/1, 0xFFFF/1 in order, first result 4 edges after first accept, then one per cycle.
- Chunk-boundary carry: a=0x0FFF, b=0x0001, cin=0 -> sum=0x1000, cout=0; carry ripples correctly through stages 0..3.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0 throughout, sum/cout stable; release -> all 4 beats drain in order with none lost or duplicated.
- Parameter sweep (WIDTH=8/STAGES=1, WIDTH=8/STAGES=8, WIDTH=32/STAGES=4): 1000 random beats with random out_ready -> every result equals the modulo reference sum and carry; latency equals STAGES.
- PIPE_ADDER_OVF_EN defined, WIDTH=16: 0x7FFF+0x0001 -> ovf=1; 0x8000+0xFFFF -> ovf=1, cout=1; 0x1234+0x0001 -> ovf=0.
